zeroriscy_ex_mc_ctrl: RTL and testbench

//  Parametrised multi-cycle issue/response controller for the EX stage. Dispatches one op at a

---
 rtl/zeroriscy_ex_mc_ctrl_pkg.sv | 16 +
 rtl/zeroriscy_ex_mc_watchdog.sv | 34 +++
 rtl/zeroriscy_ex_mc_ctrl.sv | 144 ++++++++++++++
 tb/tb_zeroriscy_ex_mc_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zeroriscy_ex_mc_ctrl_pkg.sv
// Shared types for the EX-stage multi-cycle issue/response controller.
package zeroriscy_ex_mc_ctrl_pkg;

    typedef enum logic [1:0] {
        EXMC_IDLE,
        EXMC_BUSY,
        EXMC_RESP
    } ex_mc_state_e;

    typedef enum logic [1:0] {
        EXMC_ERR_NONE,
        EXMC_ERR_TIMEOUT,
        EXMC_ERR_BAD_UNIT
    } ex_mc_err_e;

endpackage

// File: rtl/zeroriscy_ex_mc_watchdog.sv
// Saturating BUSY-cycle counter; expire flags the last allowed cycle before abort.
module zeroriscy_ex_mc_watchdog #(
    parameter int TIMEOUT = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    if (TIMEOUT == 0) begin : g_off
        logic unused_wd;
        assign unused_wd = clk ^ rst_n ^ clear ^ enable;
        assign expire    = 1'b0;
    end else begin : g_on
        localparam int CW = $clog2(TIMEOUT + 1);

        logic [CW-1:0] count_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                count_q <= '0;
            end else if (clear) begin
                count_q <= '0;
            end else if (enable && (count_q != '1)) begin
                count_q <= count_q + 1'b1;
            end
        end

        assign expire = enable && (count_q == CW'(TIMEOUT - 1));
    end

endmodule

// File: rtl/zeroriscy_ex_mc_ctrl.sv
// Dispatches one op at a time to a multi-cycle unit, registers its result and
// returns it over valid/ready, with flush, watchdog timeout and error reporting.
module zeroriscy_ex_mc_ctrl
    import zeroriscy_ex_mc_ctrl_pkg::*;
#(
    parameter  int NUM_UNITS  = 4,
    parameter  int DATA_WIDTH = 32,
    parameter  int TIMEOUT    = 0,
    localparam int UW         = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            issue_valid_i,
    input  logic [UW-1:0]                   issue_unit_i,
    output logic                            issue_ready_o,
    input  logic                            kill_i,
    output logic [NUM_UNITS-1:0]            unit_start_o,
    output logic [NUM_UNITS-1:0]            unit_kill_o,
    input  logic [NUM_UNITS-1:0]            unit_done_i,
    input  logic [NUM_UNITS*DATA_WIDTH-1:0] unit_result_i,
    output logic                            resp_valid_o,
    input  logic                            resp_ready_i,
    output logic [DATA_WIDTH-1:0]           resp_result_o,
    output logic                            resp_err_o,
    output logic                            busy_o,
    output logic                            spurious_o
);

    ex_mc_state_e          state_q, state_d;
    ex_mc_err_e            err_q, err_d;
    logic [UW-1:0]         sel_q, sel_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;

    logic [NUM_UNITS-1:0]  sel_onehot;
    logic [NUM_UNITS-1:0]  issue_onehot;
    logic                  issue_unit_ok;
    logic                  done_sel;
    logic [DATA_WIDTH-1:0] sel_result;
    logic                  wd_clear;
    logic                  wd_expire;

    always_comb begin
        sel_onehot   = '0;
        issue_onehot = '0;
        for (int unsigned k = 0; k < unsigned'(NUM_UNITS); k++) begin
            sel_onehot[k]   = (32'(sel_q) == k);
            issue_onehot[k] = (32'(issue_unit_i) == k);
        end
    end

    assign issue_unit_ok = (32'(issue_unit_i) < unsigned'(NUM_UNITS));
    assign done_sel      = |(unit_done_i & sel_onehot);
    // Only consumed when sel_q names a real unit, so the part-select stays in range.
    assign sel_result    = unit_result_i[32'(sel_q)*DATA_WIDTH +: DATA_WIDTH];

    zeroriscy_ex_mc_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (wd_clear),
        .enable (state_q == EXMC_BUSY),
        .expire (wd_expire)
    );

    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        result_d      = result_q;
        err_d         = err_q;
        unit_start_o  = '0;
        unit_kill_o   = '0;
        resp_valid_o  = 1'b0;
        issue_ready_o = 1'b0;
        wd_clear      = 1'b0;

        unique case (state_q)
            EXMC_IDLE: begin
                issue_ready_o = !kill_i;
            end
            EXMC_BUSY: begin
                if (done_sel) begin
                    state_d  = EXMC_RESP;
                    result_d = sel_result;
                    err_d    = EXMC_ERR_NONE;
                end else if (wd_expire) begin
                    unit_kill_o = sel_onehot;
                    state_d     = EXMC_RESP;
                    result_d    = '0;
                    err_d       = EXMC_ERR_TIMEOUT;
                end
            end
            EXMC_RESP: begin
                issue_ready_o = !kill_i && resp_ready_i;
                resp_valid_o  = !kill_i;
                if (resp_ready_i) begin
                    state_d = EXMC_IDLE;
                end
            end
            default: begin
                state_d = EXMC_IDLE;
            end
        endcase

        // Accept overrides the RESP->IDLE return, giving back-to-back issue without a bubble.
        if (issue_valid_i && issue_ready_o) begin
            sel_d    = issue_unit_i;
            wd_clear = 1'b1;
            if (issue_unit_ok) begin
                unit_start_o = issue_onehot;
                state_d      = EXMC_BUSY;
            end else begin
                state_d  = EXMC_RESP;
                result_d = '0;
                err_d    = EXMC_ERR_BAD_UNIT;
            end
        end

        if (kill_i) begin
            state_d     = EXMC_IDLE;
            unit_kill_o = (state_q == EXMC_BUSY) ? sel_onehot : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= EXMC_IDLE;
            sel_q    <= '0;
            result_q <= '0;
            err_q    <= EXMC_ERR_NONE;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    assign resp_result_o = result_q;
    assign resp_err_o    = (err_q != EXMC_ERR_NONE);
    assign busy_o        = (state_q != EXMC_IDLE);
    assign spurious_o    = |(unit_done_i & ~((state_q == EXMC_BUSY) ? sel_onehot : '0));

endmodule

// File: tb/tb_zeroriscy_ex_mc_ctrl.sv
// Directed plus randomized bench for zeroriscy_ex_mc_ctrl against a transaction-level model.
module tb_zeroriscy_ex_mc_ctrl;

    localparam int NU = 3;
    localparam int DW = 32;
    localparam int TO = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              issue_valid;
    logic [1:0]        issue_unit;
    logic              issue_ready;
    logic              kill;
    logic [NU-1:0]     unit_start;
    logic [NU-1:0]     unit_kill;
    logic [NU-1:0]     unit_done;
    logic [NU*DW-1:0]  unit_result;
    logic              resp_valid;
    logic              resp_ready;
    logic [DW-1:0]     resp_result;
    logic              resp_err;
    logic              busy;
    logic              spurious;

    always #5 clk = ~clk;

    zeroriscy_ex_mc_ctrl #(
        .NUM_UNITS  (NU),
        .DATA_WIDTH (DW),
        .TIMEOUT    (TO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .issue_valid_i (issue_valid),
        .issue_unit_i  (issue_unit),
        .issue_ready_o (issue_ready),
        .kill_i        (kill),
        .unit_start_o  (unit_start),
        .unit_kill_o   (unit_kill),
        .unit_done_i   (unit_done),
        .unit_result_i (unit_result),
        .resp_valid_o  (resp_valid),
        .resp_ready_i  (resp_ready),
        .resp_result_o (resp_result),
        .resp_err_o    (resp_err),
        .busy_o        (busy),
        .spurious_o    (spurious)
    );

    int checks = 0;
    int errors = 0;

    // Transaction view: an op in flight at a unit with an age, and at most one held response.
    bit          m_inflight;
    int          m_unit;
    int          m_age;
    bit          m_pend;
    logic [31:0] m_res;
    bit          m_err;

    task automatic model_reset();
        m_inflight = 0;
        m_unit     = 0;
        m_age      = 0;
        m_pend     = 0;
        m_res      = '0;
        m_err      = 0;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic [NU-1:0] own, e_start, e_kill;
        bit            e_ready, e_acc, e_valid, e_hit, e_tmo, e_spur;
        int            iu;
        logic [31:0]   hit_res;
        #1;
        if (!rst_n) model_reset();
        iu      = int'(issue_unit);
        own     = m_inflight ? (NU'(1) << m_unit) : '0;
        e_ready = !kill && !m_inflight && (!m_pend || resp_ready);
        e_acc   = issue_valid && e_ready;
        e_start = (e_acc && iu < NU) ? (NU'(1) << iu) : '0;
        e_hit   = m_inflight && unit_done[m_unit];
        e_tmo   = m_inflight && (m_age == TO - 1) && !e_hit;
        e_kill  = (kill || e_tmo) ? own : '0;
        e_valid = m_pend && !kill;
        e_spur  = |(unit_done & ~own);
        hit_res = unit_result[m_unit*DW +: DW];

        chk("issue_ready", issue_ready, e_ready);
        chk("unit_start", unit_start, e_start);
        chk("unit_kill", unit_kill, e_kill);
        chk("resp_valid", resp_valid, e_valid);
        chk("busy", busy, m_inflight || m_pend);
        chk("spurious", spurious, e_spur);
        if (e_valid) begin
            chk("resp_result", resp_result, m_res);
            chk("resp_err", resp_err, m_err);
        end

        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else if (kill) begin
            m_inflight = 0;
            m_pend     = 0;
        end else if (m_inflight) begin
            if (e_hit) begin
                m_inflight = 0;
                m_pend     = 1;
                m_res      = hit_res;
                m_err      = 0;
            end else if (e_tmo) begin
                m_inflight = 0;
                m_pend     = 1;
                m_res      = '0;
                m_err      = 1;
            end else begin
                m_age++;
            end
        end else begin
            if (m_pend && resp_ready) m_pend = 0;
            if (e_acc) begin
                if (iu >= NU) begin
                    m_pend = 1;
                    m_res  = '0;
                    m_err  = 1;
                end else begin
                    m_inflight = 1;
                    m_unit     = iu;
                    m_age      = 0;
                end
            end
        end
        #1;
    endtask

    initial begin
        rst_n       = 1'b0;
        issue_valid = 1'b0;
        issue_unit  = '0;
        kill        = 1'b0;
        unit_done   = '0;
        unit_result = '0;
        resp_ready  = 1'b0;
        model_reset();
        @(posedge clk);
        #1;

        chk("rst_ready", issue_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_valid", resp_valid, 0);
        chk("rst_start", unit_start, 0);
        chk("rst_kill", unit_kill, 0);
        chk("rst_spur", spurious, 0);
        chk("rst_result", resp_result, 0);
        chk("rst_err", resp_err, 0);
        step();
        rst_n = 1'b1;
        step();

        // Issue to unit 2, done three cycles after accept
        unit_result[2*DW +: DW] = 32'hDEADBEEF;
        issue_valid = 1'b1; issue_unit = 2'd2;
        step();
        issue_valid = 1'b0;
        step(); step();
        unit_done = 3'b100;
        step();
        unit_done = '0;
        chk("t1_valid", resp_valid, 1);
        chk("t1_result", resp_result, 32'hDEADBEEF);
        chk("t1_err", resp_err, 0);

        // Response held for five cycles, then consumed alongside a new issue
        repeat (5) step();
        chk("t2_hold", resp_result, 32'hDEADBEEF);
        unit_result[1*DW +: DW] = 32'h12345678;
        resp_ready = 1'b1; issue_valid = 1'b1; issue_unit = 2'd1;
        step();
        resp_ready = 1'b0; issue_valid = 1'b0;
        chk("t2_busy", busy, 1);
        step();
        unit_done = 3'b010;
        step();
        unit_done = '0;
        chk("t2_result", resp_result, 32'h12345678);
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;

        // Watchdog expiry on the 8th BUSY cycle
        issue_valid = 1'b1; issue_unit = 2'd0;
        step();
        issue_valid = 1'b0;
        repeat (8) step();
        chk("t3_valid", resp_valid, 1);
        chk("t3_err", resp_err, 1);
        chk("t3_result", resp_result, 0);
        resp_ready = 1'b1; issue_valid = 1'b1; issue_unit = 2'd0;
        step();
        resp_ready = 1'b0; issue_valid = 1'b0;
        repeat (7) step();
        unit_done = 3'b001; unit_result[0 +: DW] = 32'hCAFE0001;
        step();
        unit_done = '0;
        chk("t3b_err", resp_err, 0);
        chk("t3b_result", resp_result, 32'hCAFE0001);
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;

        // Flush while BUSY, then while holding a response
        issue_valid = 1'b1; issue_unit = 2'd2;
        step();
        issue_valid = 1'b0;
        step();
        kill = 1'b1;
        step();
        kill = 1'b0;
        chk("t4_busy_idle", busy, 0);
        step();
        issue_valid = 1'b1; issue_unit = 2'd1;
        step();
        issue_valid = 1'b0; unit_done = 3'b010;
        step();
        unit_done = '0;
        step();
        kill = 1'b1;
        step();
        kill = 1'b0;
        chk("t4_resp_idle", busy, 0);
        chk("t4_resp_valid", resp_valid, 0);
        step();

        // Out-of-range unit index
        issue_valid = 1'b1; issue_unit = 2'd3;
        step();
        issue_valid = 1'b0;
        chk("t5_valid", resp_valid, 1);
        chk("t5_err", resp_err, 1);
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;

        // Spurious done from a non-selected unit and while idle
        unit_result[2*DW +: DW] = 32'h0BADF00D;
        issue_valid = 1'b1; issue_unit = 2'd2;
        step();
        issue_valid = 1'b0; unit_done = 3'b001;
        step();
        unit_done = '0;
        chk("t6_still_busy", busy, 1);
        chk("t6_no_resp", resp_valid, 0);
        unit_done = 3'b100;
        step();
        unit_done = '0;
        chk("t6_result", resp_result, 32'h0BADF00D);
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0; unit_done = 3'b010;
        step();
        unit_done = '0;
        step();

        // Reset while an op is in flight
        issue_valid = 1'b1; issue_unit = 2'd0;
        step();
        issue_valid = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();

        for (int n = 0; n < 3000; n++) begin
            issue_valid = 1'($urandom_range(0, 1));
            issue_unit  = 2'($urandom_range(0, 3));
            kill        = ($urandom_range(0, 15) == 0);
            resp_ready  = 1'($urandom_range(0, 1));
            for (int k = 0; k < NU; k++) begin
                unit_done[k]           = ($urandom_range(0, 5) == 0);
                unit_result[k*DW +: DW] = $urandom;
            end
            rst_n = ($urandom_range(0, 399) != 0);
            step();
        end
        rst_n = 1'b1; issue_valid = 1'b0; kill = 1'b0; unit_done = '0; resp_ready = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
